// File: rtl/sr_ff_using_d.sv
// WIDTH-bit clocked SR flip-flop: per-bit SR next-state logic feeding a D register.
// Optional macro SR_FF_ERR_CNT_EN adds an 8-bit saturating S=R=1 edge counter with sync clear.
module sr_ff_using_d #(
    parameter int unsigned      WIDTH        = 1,
    parameter int unsigned      INVALID_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] invalid
`ifdef SR_FF_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
`endif
);

    localparam logic [1:0] MODE = 2'(INVALID_MODE);

    if (INVALID_MODE > 3) begin : g_bad_mode
        $error("sr_ff_using_d: INVALID_MODE must be in 0..3");
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("sr_ff_using_d: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] illegal_d;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] both;

    assign both = S & R;
    assign Qn   = ~Q;

    // Next state for bits that see S=R=1, fixed at elaboration by INVALID_MODE.
    always_comb begin
        illegal_d = Q;
        case (MODE)
            2'd1:    illegal_d = '1;
            2'd2:    illegal_d = '0;
            2'd3:    illegal_d = ~Q;
            default: illegal_d = Q;
        endcase
    end

    always_comb begin
        d = Q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({S[i], R[i]})
                2'b10:   d[i] = 1'b1;
                2'b01:   d[i] = 1'b0;
                2'b11:   d[i] = illegal_d[i];
                default: d[i] = Q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q       <= RESET_VAL;
            invalid <= '0;
        end else begin
            Q       <= d;
            invalid <= both;
        end
    end

`ifdef SR_FF_ERR_CNT_EN
    localparam int unsigned CNT_W = 8;

    // Saturating count of edges with any illegal bit; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if ((|both) && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_sr_ff_using_d.sv
// Scoreboard bench for sr_ff_using_d: four WIDTH=1 instances (one per INVALID_MODE) and one WIDTH=4 instance.
module tb_sr_ff_using_d;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b0;
    logic       s1     = 1'b0;
    logic       r1     = 1'b0;
    logic [3:0] s4     = '0;
    logic [3:0] r4     = '0;
    logic       err_clr = 1'b0;

    logic [3:0] q_m, qn_m, inv_m;
    logic [3:0] q_v, qn_v, inv_v;
`ifdef SR_FF_ERR_CNT_EN
    logic [7:0] cnt_m [4];
    logic [7:0] cnt_v;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q   [$];
    logic [3:0] exp_inv [$];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    for (genvar k = 0; k < 4; k++) begin : g_mode
        sr_ff_using_d #(.WIDTH(1), .INVALID_MODE(k), .RESET_VAL(1'b0)) u_m (
            .clk     (clk),
            .rst_n   (rst_n),
            .S       (s1),
            .R       (r1),
            .Q       (q_m[k]),
            .Qn      (qn_m[k]),
            .invalid (inv_m[k])
`ifdef SR_FF_ERR_CNT_EN
            ,
            .err_clr (err_clr),
            .err_cnt (cnt_m[k])
`endif
        );
    end

    sr_ff_using_d #(.WIDTH(4), .INVALID_MODE(0), .RESET_VAL(4'b0000)) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .S       (s4),
        .R       (r4),
        .Q       (q_v),
        .Qn      (qn_v),
        .invalid (inv_v)
`ifdef SR_FF_ERR_CNT_EN
        ,
        .err_clr (err_clr),
        .err_cnt (cnt_v)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic s, input logic r);
        @(negedge clk);
        s1 = s;
        r1 = r;
    endtask

    task automatic drive_v(input logic [3:0] s, input logic [3:0] r);
        @(negedge clk);
        s4 = s;
        r4 = r;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        #3;
        n_tests++;
        if (q_m !== 4'b0000) begin n_fail++; $display("FAIL reset_q_m got=%b exp=0000", q_m); end
        n_tests++;
        if (qn_m !== 4'b1111) begin n_fail++; $display("FAIL reset_qn_m got=%b exp=1111", qn_m); end
        n_tests++;
        if (inv_m !== 4'b0000) begin n_fail++; $display("FAIL reset_inv_m got=%b exp=0000", inv_m); end
        n_tests++;
        if (q_v !== 4'b0000 || qn_v !== 4'b1111) begin
            n_fail++; $display("FAIL reset_vec got q=%b qn=%b exp q=0000 qn=1111", q_v, qn_v);
        end
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(4'b0000);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (q_m !== e) begin n_fail++; $display("FAIL reset_release_edge%0d got=%b exp=%b", i, q_m, e); end
        end
    endtask

    task automatic test_set_hold_reset();
        logic       st [3] = '{1'b1, 1'b0, 1'b0};
        logic       rt [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0] et [3] = '{4'b1111, 4'b1111, 4'b0000};
        logic [3:0] e;
        for (int i = 0; i < 3; i++) begin
            drive_m(st[i], rt[i]);
            exp_q.push_back(et[i]);
            exp_inv.push_back(4'b0000);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (q_m !== e) begin n_fail++; $display("FAIL shr_q step%0d got=%b exp=%b", i, q_m, e); end
            n_tests++;
            if (qn_m !== ~e) begin n_fail++; $display("FAIL shr_qn step%0d got=%b exp=%b", i, qn_m, ~e); end
            e = exp_inv.pop_front();
            n_tests++;
            if (inv_m !== e) begin n_fail++; $display("FAIL shr_inv step%0d got=%b exp=%b", i, inv_m, e); end
        end
    endtask

    // Bit k of each expectation is the instance built with INVALID_MODE=k.
    task automatic test_illegal();
        logic       st [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       rt [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] eq [4] = '{4'b1111, 4'b0011, 4'b1011, 4'b1011};
        logic [3:0] ei [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            drive_m(st[i], rt[i]);
            exp_q.push_back(eq[i]);
            exp_inv.push_back(ei[i]);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (q_m !== e) begin n_fail++; $display("FAIL illegal_q step%0d got=%b exp=%b", i, q_m, e); end
            e = exp_inv.pop_front();
            n_tests++;
            if (inv_m !== e) begin n_fail++; $display("FAIL illegal_inv step%0d got=%b exp=%b", i, inv_m, e); end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        drive_m(1'b1, 1'b0);
        exp_q.push_back(4'b1111);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (q_m !== e) begin n_fail++; $display("FAIL arst_pre got=%b exp=%b", q_m, e); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (q_m !== 4'b0000 || qn_m !== 4'b1111 || inv_m !== 4'b0000) begin
            n_fail++; $display("FAIL arst_immediate got q=%b qn=%b inv=%b exp q=0000 qn=1111 inv=0000", q_m, qn_m, inv_m);
        end
        tick();
        n_tests++;
        if (q_m !== 4'b0000) begin n_fail++; $display("FAIL arst_held_edge got=%b exp=0000", q_m); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b1111);
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if (q_m !== e) begin n_fail++; $display("FAIL arst_release got=%b exp=%b", q_m, e); end
        drive_m(1'b0, 1'b0);
    endtask

    task automatic test_vector();
        logic [3:0] st [4] = '{4'b0101, 4'b0000, 4'b1111, 4'b0000};
        logic [3:0] rt [4] = '{4'b1010, 4'b0001, 4'b1111, 4'b0000};
        logic [3:0] eq [4] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100};
        logic [3:0] ei [4] = '{4'b0000, 4'b0000, 4'b1111, 4'b0000};
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            drive_v(st[i], rt[i]);
            exp_q.push_back(eq[i]);
            exp_inv.push_back(ei[i]);
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (q_v !== e || qn_v !== ~e) begin
                n_fail++; $display("FAIL vec_q step%0d got q=%b qn=%b exp q=%b", i, q_v, qn_v, e);
            end
            e = exp_inv.pop_front();
            n_tests++;
            if (inv_v !== e) begin n_fail++; $display("FAIL vec_inv step%0d got=%b exp=%b", i, inv_v, e); end
        end
    endtask

`ifdef SR_FF_ERR_CNT_EN
    task automatic test_err_cnt();
        @(negedge clk);
        err_clr = 1'b1;
        s1 = 1'b0;
        r1 = 1'b0;
        tick();
        n_tests++;
        if (cnt_m[0] !== 8'd0) begin n_fail++; $display("FAIL errcnt_clear got=%0d exp=0", cnt_m[0]); end
        @(negedge clk);
        err_clr = 1'b0;
        s1 = 1'b1;
        r1 = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (cnt_m[0] !== 8'd3) begin n_fail++; $display("FAIL errcnt_three got=%0d exp=3", cnt_m[0]); end
        @(negedge clk);
        err_clr = 1'b1;
        tick();
        n_tests++;
        if (cnt_m[0] !== 8'd0) begin n_fail++; $display("FAIL errcnt_clr_wins got=%0d exp=0", cnt_m[0]); end
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        n_tests++;
        if (cnt_m[0] !== 8'd255 || cnt_m[3] !== 8'd255) begin
            n_fail++; $display("FAIL errcnt_saturate got=%0d/%0d exp=255", cnt_m[0], cnt_m[3]);
        end
        n_tests++;
        if (cnt_v !== 8'd0) begin n_fail++; $display("FAIL errcnt_vec_idle got=%0d exp=0", cnt_v); end
        drive_m(1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_set_hold_reset();
        test_illegal();
        test_async_reset();
        test_vector();
`ifdef SR_FF_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
